// File: rtl/seq_ctrl_rv32i.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core.
// Gates decoded control signals into per-phase strobes, with memory timeout and fault tracking.
module seq_ctrl_rv32i #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [6:0]  opcode,
    input  logic [1:0]  cu_rdtype,
    input  logic        cu_store,
    input  logic        cu_rdwrite,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StMem    = 3'd4;
    localparam logic [2:0] StWb     = 3'd5;
    localparam logic [2:0] StFault  = 3'd6;

    localparam logic [1:0] CodeNone   = 2'b00;
    localparam logic [1:0] CodeFetch  = 2'b01;
    localparam logic [1:0] CodeIllegal = 2'b10;
    localparam logic [1:0] CodeData   = 2'b11;

    // Counter value seen on the last permitted request cycle.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [31:0]      instret_q, instret_d;
    logic             legal;
    logic             needs_mem;

    always_comb begin
        case (opcode)
            7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h67: legal = 1'b1;
            default:                    legal = 1'b0;
        endcase
    end

    assign needs_mem = (cu_rdtype == 2'b01) | cu_store;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        instret_d = instret_q;
        case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    state_d = StDecode;
                end else if (cnt_q == CntLast) begin
                    state_d = StFault;
                    code_d  = CodeFetch;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDecode: begin
                if (legal) begin
                    state_d = StExec;
                end else begin
                    state_d = StFault;
                    code_d  = CodeIllegal;
                end
            end
            StExec: begin
                if (needs_mem) begin
                    state_d = StMem;
                    cnt_d   = '0;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ack) begin
                    state_d = StWb;
                end else if (cnt_q == CntLast) begin
                    state_d = StFault;
                    code_d  = CodeData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWb: begin
                instret_d = instret_q + 32'd1;
                if (en) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            code_q    <= CodeNone;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            instret_q <= instret_d;
        end
    end

    // Strobes decode straight from the registered state so reset kills them at once.
    assign imem_req   = (state_q == StFetch);
    assign ir_we      = (state_q == StFetch) & imem_ack;
    assign dmem_req   = (state_q == StMem);
    assign dmem_we    = (state_q == StMem) & cu_store;
    assign rf_we      = (state_q == StWb) & cu_rdwrite;
    assign pc_we      = (state_q == StWb);
    assign fault      = (state_q == StFault);
    assign fault_code = code_q;
    assign state      = state_q;
    assign instret    = instret_q;

endmodule
